// File: rtl/conv_inst_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_inst_pkg : instruction field layout, opcodes, FSM encoding   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package conv_inst_pkg;

  localparam int INST_W     = 40;
  localparam int OP_MSB     = 39;
  localparam int OP_LSB     = 36;
  localparam int ADDR_MSB   = 35;
  localparam int ADDR_LSB   = 22;
  localparam int CNT_MSB    = 21;
  localparam int CNT_LSB    = 10;
  localparam int STRIDE_MSB = 9;
  localparam int STRIDE_LSB = 0;

  localparam int ADDR_FW   = ADDR_MSB - ADDR_LSB + 1;
  localparam int CNT_FW    = CNT_MSB - CNT_LSB + 1;
  localparam int STRIDE_FW = STRIDE_MSB - STRIDE_LSB + 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_SYNC = 4'h2;
  localparam logic [3:0] OP_END  = 4'hF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef struct packed {
    logic [3:0]           op;
    logic [ADDR_FW-1:0]   addr;
    logic [CNT_FW-1:0]    cnt;
    logic [STRIDE_FW-1:0] stride;
  } inst_t;

  function automatic inst_t decode_inst(input logic [INST_W-1:0] raw);
    inst_t d;
    d.op     = raw[OP_MSB:OP_LSB];
    d.addr   = raw[ADDR_MSB:ADDR_LSB];
    d.cnt    = raw[CNT_MSB:CNT_LSB];
    d.stride = raw[STRIDE_MSB:STRIDE_LSB];
    return d;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_LOAD) || (op == OP_SYNC) || (op == OP_END);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_addr_gen : burst address register, stride step, beat counter |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module conv_addr_gen #(
  parameter int AW = 14,
  parameter int CW = 12,
  parameter int SW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic [CW-1:0] load_cnt,
  input  logic [SW-1:0] load_stride,
  input  logic          step,
  output logic [AW-1:0] addr,
  output logic          last
);

  localparam int SUMW = (AW > SW) ? AW : SW;

  logic [CW-1:0]   beats_left;
  logic [SW-1:0]   stride;
  logic [SUMW-1:0] next_sum;

  // Sum is truncated to AW bits so the address wraps modulo 2^AW.
  assign next_sum = SUMW'(addr) + SUMW'(stride);
  assign last     = (beats_left == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      beats_left <= '0;
      stride     <= '0;
    end else if (load) begin
      addr       <= load_addr;
      beats_left <= load_cnt;
      stride     <= load_stride;
    end else if (step) begin
      addr       <= next_sum[AW-1:0];
      beats_left <= beats_left - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_inst_exec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | conv_inst_exec : decodes conv instructions into SRAM read bursts, |
// | sync waits and end markers. CONV_INST_EXEC_PERF_EN adds a stall   |
// | counter port. Rev 1.0                                             |
// +------------------------------------------------------------------+
module conv_inst_exec
  import conv_inst_pkg::*;
#(
  parameter int AW = 14,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [39:0]   m_inst,
  input  logic          m_valid,
  output logic          m_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          rd_last,
  input  logic          rd_ready,
  input  logic          sync_in,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef CONV_INST_EXEC_PERF_EN
  ,
  output logic [31:0]   perf_stall
`endif
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       alive;
  inst_t      dec;
  logic       accept;
  logic       beat_done;
  logic       gen_last;
  logic       load;

  assign dec       = decode_inst(m_inst);
  // alive keeps m_ready low for as long as reset is held.
  assign m_ready   = alive && (state == ST_IDLE);
  assign accept    = m_valid && m_ready;
  assign rd_en     = (state == ST_BURST);
  assign rd_last   = rd_en && gen_last;
  assign beat_done = rd_en && rd_ready;
  assign busy      = (state != ST_IDLE);
  assign load      = accept && (dec.op == OP_LOAD);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && dec.op == OP_LOAD)      state_nxt = ST_BURST;
        else if (accept && dec.op == OP_SYNC) state_nxt = ST_WAIT;
      end
      ST_BURST: if (beat_done && gen_last) state_nxt = ST_IDLE;
      ST_WAIT:  if (sync_in) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      alive <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      done  <= accept && (dec.op == OP_END);
      if (accept && !op_legal(dec.op)) err <= 1'b1;
    end
  end

  conv_addr_gen #(
    .AW (AW),
    .CW (CW),
    .SW (STRIDE_FW)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_addr   (dec.addr[AW-1:0]),
    .load_cnt    (dec.cnt[CW-1:0]),
    .load_stride (dec.stride),
    .step        (beat_done),
    .addr        (rd_addr),
    .last        (gen_last)
  );

`ifdef CONV_INST_EXEC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
    end else if (rd_en && !rd_ready && perf_stall != 32'hFFFF_FFFF) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_inst_exec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_conv_inst_exec : randomized self-checking bench for            |
// | conv_inst_exec. Rev 1.0                                           |
// +------------------------------------------------------------------+
module tb_conv_inst_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [39:0] m_inst;
  logic        m_valid;
  logic        m_ready;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic        rd_last;
  logic        rd_ready;
  logic        sync_in;
  logic        busy;
  logic        done;
  logic        err;
`ifdef CONV_INST_EXEC_PERF_EN
  logic [31:0] perf_stall;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  conv_inst_exec #(.AW(14), .CW(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m_inst   (m_inst),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_last  (rd_last),
    .rd_ready (rd_ready),
    .sync_in  (sync_in),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef CONV_INST_EXEC_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({m_ready, rd_en, rd_last, busy, done, err} !== 6'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 000000", {m_ready, rd_en, rd_last, busy, done, err});
    end
    vecs++; if (rd_addr !== 14'h0) begin
      errs++; $display("FAIL reset_addr: got %h want 0000", rd_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++; if (m_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_release: m_ready=%b busy=%b want 1 0", m_ready, busy);
    end
  endtask

  // mode 0: rd_ready always 1; 1: two stall cycles on beat 2; 2: random rd_ready
  task automatic test_load(input logic [13:0] a, input logic [11:0] c, input logic [9:0] s, input int mode);
    int k = 0;
    int budget = 0;
    int stall_left = 2;
    logic [13:0] exp_addr;
    rd_ready = 1'b0;
    m_inst   = {4'h1, a, c, s};
    m_valid  = 1'b1;
    vecs++; if (m_ready !== 1'b1) begin
      errs++; $display("FAIL load_accept_ready: got %b want 1", m_ready);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    m_inst  = 40'($urandom);
    while (k <= int'(c) && budget < 20000) begin
      exp_addr = 14'((int'(a) + k * int'(s)) % 16384);
      vecs++; if (rd_en !== 1'b1 || busy !== 1'b1 || m_ready !== 1'b0) begin
        errs++; $display("FAIL load_ctrl beat %0d: rd_en=%b busy=%b m_ready=%b want 1 1 0", k, rd_en, busy, m_ready);
      end
      vecs++; if (rd_addr !== exp_addr) begin
        errs++; $display("FAIL load_addr beat %0d: got %h want %h", k, rd_addr, exp_addr);
      end
      vecs++; if (rd_last !== (k == int'(c))) begin
        errs++; $display("FAIL load_last beat %0d: got %b want %b", k, rd_last, (k == int'(c)));
      end
      if (mode == 0) rd_ready = 1'b1;
      else if (mode == 1) begin
        if (k == 1 && stall_left > 0) begin rd_ready = 1'b0; stall_left--; end
        else rd_ready = 1'b1;
      end else rd_ready = 1'($urandom);
      @(posedge clk); #1;
      if (rd_ready) k++;
      budget++;
    end
    rd_ready = 1'b0;
    vecs++; if (budget >= 20000) begin
      errs++; $display("FAIL load_timeout: got %0d beats want %0d", k, int'(c) + 1);
    end
    vecs++; if (rd_en !== 1'b0 || rd_last !== 1'b0 || m_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL load_end: rd_en=%b rd_last=%b m_ready=%b busy=%b want 0 0 1 0", rd_en, rd_last, m_ready, busy);
    end
  endtask

  task automatic test_sync(input int n);
    sync_in = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b0;
    m_inst  = {4'h2, 36'($urandom)};
    m_valid = 1'b1;
    vecs++; if (m_ready !== 1'b1) begin
      errs++; $display("FAIL sync_accept_ready: got %b want 1", m_ready);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      vecs++; if (busy !== 1'b1 || m_ready !== 1'b0 || rd_en !== 1'b0) begin
        errs++; $display("FAIL sync_wait cycle %0d: busy=%b m_ready=%b rd_en=%b want 1 0 0", i, busy, m_ready, rd_en);
      end
      if (i == n - 1) sync_in = 1'b1;
      @(posedge clk); #1;
      sync_in = 1'b0;
    end
    vecs++; if (busy !== 1'b0 || m_ready !== 1'b1) begin
      errs++; $display("FAIL sync_release: busy=%b m_ready=%b want 0 1", busy, m_ready);
    end
  endtask

  task automatic test_end;
    m_inst  = {4'hF, 36'($urandom)};
    m_valid = 1'b1;
    vecs++; if (done !== 1'b0) begin
      errs++; $display("FAIL end_pre: done=%b want 0", done);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    vecs++; if (done !== 1'b1 || busy !== 1'b0 || m_ready !== 1'b1) begin
      errs++; $display("FAIL end_pulse: done=%b busy=%b m_ready=%b want 1 0 1", done, busy, m_ready);
    end
    @(posedge clk); #1;
    vecs++; if (done !== 1'b0) begin
      errs++; $display("FAIL end_width: done=%b want 0", done);
    end
  endtask

  task automatic test_err;
    logic [3:0] bad_ops [3] = '{4'h7, 4'h3, 4'hE};
    vecs++; if (err !== 1'b0) begin
      errs++; $display("FAIL err_pre: err=%b want 0", err);
    end
    m_inst  = {bad_ops[0], 36'($urandom)};
    m_valid = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    vecs++; if (err !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
      errs++; $display("FAIL err_set: err=%b busy=%b rd_en=%b want 1 0 0", err, busy, rd_en);
    end
    for (int i = 0; i < 4; i++) begin
      m_inst  = (i % 2 == 0) ? {4'h0, 36'($urandom)} : {bad_ops[1 + i / 2], 36'($urandom)};
      m_valid = 1'b1;
      @(posedge clk); #1;
      m_valid = 1'b0;
      vecs++; if (err !== 1'b1 || busy !== 1'b0) begin
        errs++; $display("FAIL err_sticky %0d: err=%b busy=%b want 1 0", i, err, busy);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [13:0] a = 14'($urandom);
    logic [9:0]  s = 10'($urandom);
    logic [13:0] exp_addr;
    rd_ready = 1'b1;
    m_inst   = {4'h1, a, 12'd7, s};
    m_valid  = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    @(posedge clk); #1;
    exp_addr = 14'((int'(a) + int'(s)) % 16384);
    vecs++; if (rd_en !== 1'b1 || rd_addr !== exp_addr) begin
      errs++; $display("FAIL rstmid_beat2: rd_en=%b rd_addr=%h want 1 %h", rd_en, rd_addr, exp_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({rd_en, rd_last, busy, m_ready, done, err} !== 6'b0 || rd_addr !== 14'h0) begin
      errs++; $display("FAIL rstmid_clear: flags=%b rd_addr=%h want 000000 0000", {rd_en, rd_last, busy, m_ready, done, err}, rd_addr);
    end
    rd_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_inst  = {4'h0, 36'($urandom)};
    m_valid = 1'b1;
    vecs++; if (m_ready !== 1'b1) begin
      errs++; $display("FAIL rstmid_ready: got %b want 1", m_ready);
    end
    @(posedge clk); #1;
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (rd_en !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL rstmid_nop %0d: rd_en=%b busy=%b want 0 0", i, rd_en, busy);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef CONV_INST_EXEC_PERF_EN
  task automatic test_perf;
    vecs++; if (perf_stall !== 32'd0) begin
      errs++; $display("FAIL perf_reset: got %0d want 0", perf_stall);
    end
    rd_ready = 1'b0;
    m_inst   = {4'h1, 14'h0200, 12'd1, 10'd2};
    m_valid  = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rd_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rd_ready = 1'b0;
    vecs++; if (perf_stall !== 32'd3 || busy !== 1'b0) begin
      errs++; $display("FAIL perf_count: perf_stall=%0d busy=%b want 3 0", perf_stall, busy);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    m_inst   = '0;
    m_valid  = 1'b0;
    rd_ready = 1'b0;
    sync_in  = 1'b0;
    test_reset;
    test_load(14'h0100, 12'd3, 10'd4, 0);
    test_load(14'h0100, 12'd3, 10'd4, 1);
    test_load(14'h3FFE, 12'd3, 10'd1, 0);
    test_load(14'($urandom), 12'd0, 10'($urandom), 0);
    test_sync(5);
    test_sync(int'($urandom_range(1, 8)));
    test_end;
    for (int i = 0; i < 20; i++) begin
      test_load(14'($urandom), 12'($urandom_range(0, 15)), 10'($urandom), 2);
    end
    test_end;
    test_err;
    test_reset_mid_burst;
`ifdef CONV_INST_EXEC_PERF_EN
    test_perf;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
